// File: rtl/cirno_pkg.sv
// Shared definitions for the cirno core and its host-side run controller.
package cirno_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, INIT, RUN, FINISH} run_state_t;

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear (priority over enable) and a
// combinational flag that is high while the count equals term.
module cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (clr)                count <= '0;
    else if (en && count != '1)  count <= count + 1'b1;
  end

  assign match = (count == term);

endmodule

// File: rtl/run_controller.sv
// Host-side initiator for the cirno init/done run handshake: pulses core_init,
// then counts RUN cycles until an armed done or the cycle budget runs out.
// Define RUN_CTRL_STATS_EN to add the run_total / cycle_total statistics outputs.
module run_controller #(
  parameter int          ADDR_W      = cirno_pkg::ADDR_W,
  parameter int          CNT_W       = 16,
  parameter int          INIT_CYCLES = 2,
  parameter int unsigned MAX_CYCLES  = 'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              core_init,
  output logic [ADDR_W-1:0] core_start_addr,
  input  logic              core_done,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
`ifdef RUN_CTRL_STATS_EN
  ,
  output logic [7:0]        run_total,
  output logic [31:0]       cycle_total
`endif
);
  import cirno_pkg::*;

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  run_state_t state, state_nx;
  logic       accept, init_last, at_limit, complete, timeout, armed;
  logic [INIT_W-1:0] init_cnt_unused;

  assign accept   = (state == IDLE) && start;
  // armed is registered, so a done that is still high from the last program
  // must drop for at least one RUN cycle before it can complete this one.
  assign complete = (state == RUN) && armed && core_done;
  assign timeout  = (state == RUN) && at_limit && !complete;

  cycle_counter #(.W(INIT_W)) u_init_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != INIT),
    .en    (state == INIT),
    .term  (INIT_W'(INIT_CYCLES - 1)),
    .count (init_cnt_unused),
    .match (init_last)
  );

  // at_limit flags the cycle whose increment lands on MAX_CYCLES.
  cycle_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (state == RUN),
    .term  (CNT_W'(MAX_CYCLES - 1)),
    .count (cycle_count),
    .match (at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)               state_nx = INIT;
      INIT:    if (init_last)           state_nx = RUN;
      RUN:     if (complete || timeout) state_nx = FINISH;
      FINISH:                           state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_start_addr <= '0;
      timed_out       <= 1'b0;
      armed           <= 1'b0;
    end else if (accept) begin
      core_start_addr <= start_addr;
      timed_out       <= 1'b0;
      armed           <= 1'b0;
    end else if (state == RUN) begin
      if (!core_done) armed     <= 1'b1;
      if (timeout)    timed_out <= 1'b1;
    end
  end

  assign core_init = (state == INIT);
  assign busy      = (state != IDLE);
  // In FINISH, timed_out describes the run just ended.
  assign finished  = (state == FINISH) && !timed_out;

`ifdef RUN_CTRL_STATS_EN
  logic [32:0] cycle_sum;

  assign cycle_sum = {1'b0, cycle_total} + 33'(cycle_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_total   <= '0;
      cycle_total <= '0;
    end else if (finished) begin
      if (run_total != '1) run_total <= run_total + 1'b1;
      cycle_total <= cycle_sum[32] ? '1 : cycle_sum[31:0];
    end
  end
`endif

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Host-side initiator for the cirno core's init/done run handshake; the core is the responder.
- Accepts a run request with a program start address, drives the core's init and startAddress, then counts execution cycles until the core raises done.
- Reports completion, cycle count and timeout status to the bench or host.
- Sits beside top_level in system-level testbenches and any multi-program wrapper.

Parameters:
ADDR_W, 9, width of program start address (matches 9-bit instruction address)
CNT_W, 16, width of cycle counter
INIT_CYCLES, 2, number of cycles core_init is held high per run (min 1)
MAX_CYCLES, 16'hFFFF, cycle budget before timeout is declared (must be < 2^CNT_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  run request, sampled only in IDLE
start_addr  input  ADDR_W  program start address, captured with start
core_init  output  1  drives core init
core_start_addr  output  ADDR_W  drives core startAddress, stable for whole run
core_done  input  1  done from core
busy  output  1  high from accept until return to IDLE
finished  output  1  one-cycle pulse on normal completion
timed_out  output  1  sticky; set on timeout, cleared by next accepted start or rst
cycle_count  output  CNT_W  cycles counted in RUN; frozen after finish or timeout

Behaviour:
- Reset (async, any state): state=IDLE, core_init=0, core_start_addr=0, busy=0, finished=0, timed_out=0, cycle_count=0, armed=0.
- IDLE:
  - start=1 -> capture start_addr into core_start_addr, clear cycle_count and timed_out, set busy, go INIT.
  - start=0 -> remain IDLE; all outputs hold.
- INIT:
  - core_init=1 for exactly INIT_CYCLES cycles (internal counter), then core_init=0 and go RUN.
  - core_done is ignored during INIT.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - armed flag sets on the first cycle core_done=0. This rejects a stale done held high from the previous program.
  - Completion when armed=1 and core_done=1: go FINISH. The completing cycle is counted.
  - If cycle_count reaches MAX_CYCLES with no completion: set timed_out, go FINISH.
  - If completion and timeout occur in the same cycle, completion wins: finished pulses and timed_out stays 0.
- FINISH:
  - One cycle. finished=1 only for a normal completion, not for a timeout.
  - busy=0 on the next cycle; go IDLE.
  - start asserted during FINISH is ignored. A new start is accepted in IDLE at the earliest one cycle after finished.
- start while busy is ignored, with no queuing.
- Latency:
  - start sampled at edge N -> core_init high from N+1 through N+INIT_CYCLES.
  - RUN begins at N+INIT_CYCLES+1.
- core_start_addr changes only on an accepted start.
- Reset mid-run: all state cleared immediately, including a low core_init. The core sees no init until the next start.

Optional Feature:
- Macro: RUN_CTRL_STATS_EN.
- Defined:
  - Adds outputs run_total (8-bit, completed runs, saturating) and cycle_total (32-bit, sum of cycle_count over completed runs, saturating).
  - Both update in FINISH on completion only; timeouts are not added.
  - Both cleared only by rst.
- Undefined: the ports and logic are absent; the base behaviour is unchanged.

Decomposition:
- Shared package cirno_pkg holds:
  - run_state_t enum {IDLE, INIT, RUN, FINISH}.
  - Localparams ADDR_W=9 and DATA_W=8, reused by core blocks.
- Sub-module cycle_counter: saturating up-counter with clear, enable and a terminal-match flag. Instantiated for cycle_count. Reused for the INIT hold counter with width 2.

Test Plan:
- Normal run: start=1, start_addr=9'h020; core model holds done=0, then raises done after 37 RUN cycles -> core_init high for 2 cycles, core_start_addr=0x020, finished pulses once, cycle_count=37, timed_out=0, busy low next cycle.
- Stale done: core_done held 1 through INIT and the first 5 RUN cycles, then 0 for 3 cycles, then 1 -> completion only after re-rise, cycle_count=9.
- Timeout: MAX_CYCLES=100, core_done never rises -> timed_out=1 at cycle_count=100, no finished pulse, return to IDLE; the next start clears timed_out.
- Start while busy: second start with addr 0x055 during RUN -> ignored, core_start_addr stays 0x020; start during FINISH is also ignored.
- Async reset mid-INIT: rst pulsed on the second INIT cycle -> core_init=0 immediately, all outputs at reset values, next start behaves as a fresh run.
- RUN_CTRL_STATS_EN: three completions of 10, 20 and 30 cycles plus one timeout -> run_total=3, cycle_total=60.
